// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg: shared state type, size limits and modulo-N pointer helper
package prio_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int MIN_N = 2;
  localparam int MAX_N = 32;
  function automatic logic [4:0] dec_mod(input logic [4:0] v, input logic [5:0] n);
    return (v == 5'd0) ? 5'(n - 6'd1) : v - 5'd1;
  endfunction
endpackage

// File: rtl/prio_select.sv
// prio_select: finds the first set request walking downward from a base pointer, wrapping mod N
module prio_select
  import prio_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_base,
  input  logic         i_rr_en,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  logic [W-1:0] w_c;
  logic         w_found;
  // fixed mode is round-robin from base 0, whose order is N-1 down to 0
  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    w_c     = i_rr_en ? i_base : '0;
    for (int s = 0; s < N; s++) begin
      w_c = W'(dec_mod(5'(w_c), 6'(N)));
      if (!w_found && i_req[w_c]) begin
        o_idx   = w_c;
        w_found = 1'b1;
      end
    end
  end
  assign o_any = |i_req;
endmodule

// File: rtl/priority_arbiter_n.sv
// priority_arbiter_n: registered N-input arbiter, fixed or round-robin, with sticky valid/ack grant
module priority_arbiter_n
  import prio_arb_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         rr_en,
  input  logic         ack,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] last_idx
);
  if (N < MIN_N || N > MAX_N) begin : g_bad_n
    $error("priority_arbiter_n: N out of range");
  end
  state_t       r_state, w_next;
  logic [W-1:0] r_idx, r_last, w_base, w_win;
  logic [N-1:0] r_oh;
  logic         w_accept, w_take, w_any;
  assign w_accept = (r_state == GRANT) && ack;
  assign w_take   = (r_state == IDLE) || ack;
  // a back-to-back arbitration already sees the grant being accepted as the pointer
  assign w_base   = w_accept ? r_idx : r_last;
  prio_select #(.N(N), .W(W)) u_sel (
    .i_req  (req),
    .i_base (w_base),
    .i_rr_en(rr_en),
    .o_idx  (w_win),
    .o_any  (w_any)
  );
  always_comb w_next = w_take ? (w_any ? GRANT : IDLE) : r_state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_last  <= '0;
      r_oh    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_last <= r_idx;
      if (w_take && w_any) r_idx <= w_win;
      if (w_take) r_oh <= w_any ? (N'(1) << w_win) : '0;
    end
  end
  assign grant_valid  = (r_state == GRANT);
  assign grant_idx    = r_idx;
  assign grant_onehot = r_oh;
  assign last_idx     = r_last;
endmodule

// File: tb/tb_priority_arbiter_n.sv
// tb_priority_arbiter_n: N=8 and N=6 arbiters checked every cycle against a behavioural model
module tb_priority_arbiter_n;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req8 = 8'hFF;
  logic [5:0] req6 = 6'h3F;
  logic       rr_en = 1'b0;
  logic       ack = 1'b0;
  logic       gv8, gv6;
  logic [2:0] gi8, gi6, gl8, gl6;
  logic [7:0] go8;
  logic [5:0] go6;
  int checks = 0;
  int errors = 0;
  bit mv[2] = '{0, 0};
  int mi[2] = '{0, 0};
  int ml[2] = '{0, 0};

  always #5 clk = ~clk;

  priority_arbiter_n #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .rr_en(rr_en), .ack(ack),
    .grant_valid(gv8), .grant_idx(gi8), .grant_onehot(go8), .last_idx(gl8)
  );
  priority_arbiter_n #(.N(6)) u6 (
    .clk(clk), .rst_n(rst_n), .req(req6), .rr_en(rr_en), .ack(ack),
    .grant_valid(gv6), .grant_idx(gi6), .grant_onehot(go6), .last_idx(gl6)
  );

  // first requester in the order base-1, base-2, ... mod n, ending at base; -1 if none
  function automatic int winner(input bit [31:0] r, input int n, input int base, input bit rr);
    int b;
    b = rr ? base : 0;
    for (int j = 1; j <= n; j++) begin
      int c;
      c = (((b - j) % n) + n) % n;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mv[k] <= 0; mi[k] <= 0; ml[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int n, b, w;
        bit [31:0] r;
        n = (k == 0) ? 8 : 6;
        r = (k == 0) ? {24'd0, req8} : {26'd0, req6};
        if (!mv[k] || ack) begin
          b = (mv[k] && ack) ? mi[k] : ml[k];
          if (mv[k] && ack) ml[k] <= mi[k];
          w = winner(r, n, b, rr_en);
          mv[k] <= (w >= 0);
          if (w >= 0) mi[k] <= w;
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("valid8", int'(gv8), int'(mv[0]));
    chk("idx8", int'(gi8), mi[0]);
    chk("onehot8", int'(go8), mv[0] ? (1 << mi[0]) : 0);
    chk("last8", int'(gl8), ml[0]);
    chk("valid6", int'(gv6), int'(mv[1]));
    chk("idx6", int'(gi6), mi[1]);
    chk("onehot6", int'(go6), mv[1] ? (1 << mi[1]) : 0);
    chk("last6", int'(gl6), ml[1]);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_valid", int'(gv8), 0);
    chk("rst_onehot", int'(go8), 0);
    chk("rst_last", int'(gl8), 0);
    rst_n = 1'b1; req8 = 8'h00; req6 = 6'h00; ack = 1'b1; rr_en = 1'b0;
    step();
    chk("idle_valid", int'(gv8), 0);
    req8 = 8'b0001; step(); chk("fix_0001", int'(gi8), 0);
    req8 = 8'b1010; step(); chk("fix_1010", int'(gi8), 3);
    req8 = 8'b0110; step(); chk("fix_0110", int'(gi8), 2);
    chk("model_fix", mi[0], 2);
    req8 = 8'b0000; step(); chk("fix_drop", int'(gv8), 0);
    chk("fix_last", int'(gl8), 2);
    ack = 1'b0; req8 = 8'h81; step(); chk("sticky_idx", int'(gi8), 7);
    req8 = 8'h00;
    repeat (5) step();
    chk("sticky_hold", int'(gi8), 7);
    chk("sticky_oh", int'(go8), 8'h80);
    chk("sticky_valid", int'(gv8), 1);
    ack = 1'b1; step(); chk("sticky_rel", int'(gv8), 0);
    ack = 1'b0; req8 = 8'h0F; step();
    chk("pre_rst_valid", int'(gv8), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", int'(gv8), 0);
    chk("async_rst_oh", int'(go8), 0);
    step(); rst_n = 1'b1;
    rr_en = 1'b1; ack = 1'b1; req8 = 8'b1111; req6 = 6'b100001;
    step(); chk("rr_a", int'(gi8), 3); chk("rr_la", int'(gl8), 0); chk("wrap_a", int'(gi6), 5);
    step(); chk("rr_b", int'(gi8), 2); chk("rr_lb", int'(gl8), 3); chk("wrap_b", int'(gi6), 0);
    step(); chk("rr_c", int'(gi8), 1); chk("rr_lc", int'(gl8), 2); chk("wrap_c", int'(gi6), 5);
    chk("model_wrap", mi[1], 5);
    step(); chk("rr_d", int'(gi8), 0);
    step(); chk("rr_e", int'(gi8), 3); chk("rr_le", int'(gl8), 0);
    step(); chk("rr_f", int'(gi8), 2);
    req8 = 8'h00; req6 = 6'h00; step();
    ack = 1'b0; rr_en = 1'b0; req8 = 8'b0011; step(); chk("ms_grant", int'(gi8), 1);
    rr_en = 1'b1; step(); rr_en = 1'b0; step(); rr_en = 1'b1; step();
    chk("ms_hold", int'(gi8), 1);
    rr_en = 1'b0; ack = 1'b1;
    step(); chk("ms_fix1", int'(gi8), 1);
    step(); chk("ms_fix2", int'(gi8), 1);
    rr_en = 1'b1;
    step(); chk("ms_rr1", int'(gi8), 0);
    step(); chk("ms_rr2", int'(gi8), 1);
    for (int i = 0; i < 3000; i++) begin
      req8  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      req6  = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom);
      ack   = ($urandom_range(0, 2) != 0);
      rr_en = (i % 600 < 300) ? 1'b1 : 1'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
